// File: rtl/fft_feeder_pkg.sv
// Shared types and helpers for the FFT frame feeder: state encoding,
// address-width derivation and the TDATA packing rule.
package fft_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2
  } state_t;

  // Widest sample the packing helper carries; callers truncate to 2*SAMPLE_W.
  localparam int unsigned MAX_SAMPLE_W = 64;

  function automatic int unsigned addr_width(input int unsigned frame_len);
    return (frame_len < 2) ? 1 : $clog2(frame_len);
  endfunction

  // Real part in the low half, imaginary half zero-filled. The input is
  // zero-extended, so truncating the result to 2*SAMPLE_W leaves
  // {imag = SAMPLE_W'(0), real}.
  function automatic logic [2*MAX_SAMPLE_W-1:0] pack_tdata(
    input logic [MAX_SAMPLE_W-1:0] re
  );
    return {{MAX_SAMPLE_W{1'b0}}, re};
  endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// Simple dual-port frame buffer: one synchronous write port and one read
// port with a single registered read stage. Contents are not reset.
module fft_frame_ram
  import fft_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the read register is reset, so the output bus is 0 after reset.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers one frame of real ADC samples and streams it to the FFT AXI4-Stream
// data input. Optional FFT event checking is enabled by FFT_FEEDER_EVENT_CHECK_EN.
module fft_frame_feeder
  import fft_feeder_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  cfg_complete,
  input  logic [SAMPLE_W-1:0]   sample_data,
  input  logic                  sample_valid,
  output logic [2*SAMPLE_W-1:0] m_axis_data_tdata,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready,
  output logic                  m_axis_data_tlast,
  output logic                  frame_sent,
  output logic                  overrun,
`ifdef FFT_FEEDER_EVENT_CHECK_EN
  input  logic                  event_tlast_unexpected,
  input  logic                  event_tlast_missing,
  output logic                  fft_frame_error,
`endif
  output logic                  busy
);

  localparam int unsigned AW = addr_width(FRAME_LEN);
  localparam int unsigned TW = 2 * SAMPLE_W;
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  state_t state, state_nxt;

  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_addr;
  logic [SAMPLE_W-1:0] rd_data;
  logic                tvalid_q;
  logic                tlast_q;
  logic                frame_sent_q;
  logic                overrun_q;

  logic advance;
  logic final_beat;
  logic wr_en;
  logic rd_en;

  always_comb begin
    advance    = !tvalid_q || m_axis_data_tready;
    final_beat = tvalid_q && m_axis_data_tready && tlast_q;
    wr_en      = (state == FILL) && cfg_complete && sample_valid;
    // Once the last beat sits in the output register no further reads issue.
    rd_en      = (state == SEND) && advance && !(tvalid_q && tlast_q);

    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_complete) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (!cfg_complete) begin
          state_nxt = IDLE;
        end else if (wr_en && (wr_ptr == LAST_IDX)) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (final_beat) begin
          state_nxt = cfg_complete ? FILL : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      wr_ptr       <= '0;
      rd_addr      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      frame_sent_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_sent_q <= final_beat;

      if ((state == SEND) && sample_valid) begin
        overrun_q <= 1'b1;
      end

      if ((state != FILL) || !cfg_complete) begin
        wr_ptr <= '0;
      end else if (wr_en) begin
        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
      end

      if (rd_en) begin
        rd_addr <= (rd_addr == LAST_IDX) ? '0 : rd_addr + AW'(1);
      end else if (state != SEND) begin
        rd_addr <= '0;
      end

      // The RAM read register is the output data register; tvalid/tlast
      // track the read that was issued alongside it.
      if (rd_en) begin
        tvalid_q <= 1'b1;
        tlast_q  <= (rd_addr == LAST_IDX);
      end else if (advance) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
    end
  end

  fft_frame_ram #(
    .DEPTH (FRAME_LEN),
    .WIDTH (SAMPLE_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset_b (reset_b),
    .we      (wr_en),
    .waddr   (wr_ptr),
    .wdata   (sample_data),
    .re      (rd_en),
    .raddr   (rd_addr),
    .rdata   (rd_data)
  );

  assign m_axis_data_tdata  = TW'(pack_tdata(MAX_SAMPLE_W'(rd_data)));
  assign m_axis_data_tvalid = tvalid_q;
  assign m_axis_data_tlast  = tlast_q;
  assign frame_sent         = frame_sent_q;
  assign overrun            = overrun_q;
  assign busy               = (state != IDLE);

`ifdef FFT_FEEDER_EVENT_CHECK_EN
  logic frame_error_q;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      frame_error_q <= 1'b0;
    end else if (event_tlast_unexpected || event_tlast_missing) begin
      frame_error_q <= 1'b1;
    end
  end

  assign fft_frame_error = frame_error_q;
`endif

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed/randomised self-checking bench for fft_frame_feeder (FRAME_LEN=8,
// SAMPLE_W=16) against a queue-based frame model.
module tb_fft_frame_feeder;

  localparam int unsigned SW = 16;
  localparam int unsigned FL = 8;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          cfg_complete = 1'b0;
  logic [SW-1:0] sample_data = '0;
  logic          sample_valid = 1'b0;
  logic          tready = 1'b0;
  logic [2*SW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          frame_sent;
  logic          overrun;
  logic          busy;
`ifdef FFT_FEEDER_EVENT_CHECK_EN
  logic          ev_unexp = 1'b0;
  logic          ev_miss = 1'b0;
  logic          frame_err;
`endif

  int unsigned n_assert = 0;
  int unsigned n_fail = 0;
  logic [SW-1:0] frame_q[$];

  fft_frame_feeder #(
    .SAMPLE_W  (SW),
    .FRAME_LEN (FL)
  ) dut (
    .clk                (clk),
    .reset_b            (reset_b),
    .cfg_complete       (cfg_complete),
    .sample_data        (sample_data),
    .sample_valid       (sample_valid),
    .m_axis_data_tdata  (tdata),
    .m_axis_data_tvalid (tvalid),
    .m_axis_data_tready (tready),
    .m_axis_data_tlast  (tlast),
    .frame_sent         (frame_sent),
    .overrun            (overrun),
`ifdef FFT_FEEDER_EVENT_CHECK_EN
    .event_tlast_unexpected (ev_unexp),
    .event_tlast_missing    (ev_miss),
    .fft_frame_error        (frame_err),
`endif
    .busy               (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Feed one full frame; the model frame is exactly the accepted samples.
  task automatic fill(input bit seq, input bit gaps);
    frame_q.delete();
    for (int i = 0; i < int'(FL); i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        sample_valid = 1'b0;
        step();
      end
      sample_data  = seq ? SW'(i + 1) : SW'($urandom);
      sample_valid = 1'b1;
      frame_q.push_back(sample_data);
      step();
    end
    sample_valid = 1'b0;
  endtask

  // Accept beats; mode 0 = tready always high, mode 1 = 1,0,0,1 pattern.
  task automatic recv(input int mode, input int stop_after, input bit junk_last,
                      output int cycles);
    int k = 0;
    bit held = 1'b0;
    logic [2*SW-1:0] held_data = '0;
    cycles = 0;
    while ((k < stop_after) && (cycles < 100)) begin
      tready = (mode == 0) ? 1'b1 : (((cycles % 4) == 0) || ((cycles % 4) == 3));
      sample_valid = 1'b0;
      if (held) begin
        chk("hold_valid", 64'(tvalid), 64'(1));
        chk("hold_data", 64'(tdata), 64'(held_data));
      end
      if (tvalid && tready) begin
        chk("beat_data", 64'(tdata), 64'({SW'(0), frame_q[k]}));
        chk("beat_last", 64'(tlast), 64'(k == int'(FL) - 1));
        if (junk_last && (k == int'(FL) - 1)) begin
          sample_data  = SW'($urandom);
          sample_valid = 1'b1;
        end
        k++;
        held = 1'b0;
      end else begin
        held      = tvalid;
        held_data = tdata;
      end
      cycles++;
      step();
    end
    sample_valid = 1'b0;
    tready = 1'b0;
    chk("beat_count", 64'(k), 64'(stop_after));
  endtask

  initial begin
    int cyc;

    // Reset state
    reset_b = 1'b0;
    step();
    step();
    chk("rst_tvalid", 64'(tvalid), 64'(0));
    chk("rst_tlast", 64'(tlast), 64'(0));
    chk("rst_tdata", 64'(tdata), 64'(0));
    chk("rst_frame_sent", 64'(frame_sent), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    reset_b = 1'b1;

    // Samples while unconfigured are dropped silently
    for (int i = 0; i < 20; i++) begin
      sample_data  = SW'($urandom);
      sample_valid = 1'b1;
      step();
      chk("idle_tvalid", 64'(tvalid), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
    end
    sample_valid = 1'b0;
    chk("idle_overrun", 64'(overrun), 64'(0));

    // Partial frame discarded when cfg_complete drops during FILL
    cfg_complete = 1'b1;
    step();
    chk("fill_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 3; i++) begin
      sample_data  = SW'(16'hDEAD + i);
      sample_valid = 1'b1;
      step();
    end
    sample_valid = 1'b0;
    cfg_complete = 1'b0;
    step();
    chk("abort_busy", 64'(busy), 64'(0));
    cfg_complete = 1'b1;
    step();

    // Sequential frame 1..8, latency and back-to-back streaming
    fill(1'b1, 1'b0);
    chk("lat_n1_tvalid", 64'(tvalid), 64'(0));
    step();
    chk("lat_n2_tvalid", 64'(tvalid), 64'(1));
    chk("lat_n2_tdata", 64'(tdata), 64'(32'h0000_0001));
    recv(0, FL, 1'b0, cyc);
    chk("stream_cycles", 64'(cyc), 64'(FL));
    chk("frame_sent_pulse", 64'(frame_sent), 64'(1));
    chk("post_tvalid", 64'(tvalid), 64'(0));
    chk("post_busy", 64'(busy), 64'(1));
    step();
    chk("frame_sent_clear", 64'(frame_sent), 64'(0));

    // Random frame under 1,0,0,1 backpressure
    fill(1'b0, 1'b1);
    recv(1, FL, 1'b0, cyc);
    chk("bp_frame_sent", 64'(frame_sent), 64'(1));
    step();
    chk("bp_no_extra", 64'(tvalid), 64'(0));
    chk("bp_overrun", 64'(overrun), 64'(0));

    // Overrun from samples during SEND, including one on the final handshake
    fill(1'b0, 1'b1);
    sample_data  = SW'($urandom);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("ovr_set", 64'(overrun), 64'(1));
    recv(0, FL, 1'b1, cyc);
    chk("ovr_frame_sent", 64'(frame_sent), 64'(1));
    chk("ovr_sticky", 64'(overrun), 64'(1));
    fill(1'b0, 1'b1);
    recv(1, FL, 1'b0, cyc);
    chk("ovr_sticky2", 64'(overrun), 64'(1));

    // Reset mid-frame after beat 3
    fill(1'b0, 1'b0);
    recv(0, 4, 1'b0, cyc);
    reset_b = 1'b0;
    step();
    chk("mid_rst_tvalid", 64'(tvalid), 64'(0));
    chk("mid_rst_tlast", 64'(tlast), 64'(0));
    chk("mid_rst_tdata", 64'(tdata), 64'(0));
    chk("mid_rst_overrun", 64'(overrun), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_frame_sent", 64'(frame_sent), 64'(0));
    reset_b = 1'b1;
    step();
    chk("refill_busy", 64'(busy), 64'(1));
    fill(1'b0, 1'b1);
    recv(1, FL, 1'b0, cyc);
    chk("refill_frame_sent", 64'(frame_sent), 64'(1));
    chk("refill_overrun", 64'(overrun), 64'(0));

`ifdef FFT_FEEDER_EVENT_CHECK_EN
    ev_miss = 1'b1;
    step();
    ev_miss = 1'b0;
    chk("err_set", 64'(frame_err), 64'(1));
    step();
    step();
    chk("err_sticky", 64'(frame_err), 64'(1));
    reset_b = 1'b0;
    step();
    reset_b = 1'b1;
    chk("err_reset", 64'(frame_err), 64'(0));
    ev_unexp = 1'b1;
    step();
    ev_unexp = 1'b0;
    chk("err_unexp", 64'(frame_err), 64'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
